// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receiver frame sequencer. Tracks the start/data/parity/stop
//            bit sequence with an edge counter (cycle inside a bit) and a bit
//            counter, strobes the sampler/deserializer/checkers, and turns the
//            checker flags into a one-cycle data_valid or frame_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PS_WIDTH   = 6,
  parameter int BC_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RX_IN,
  input  logic                PAR_EN,
  input  logic [PS_WIDTH-1:0] Prescale,
  input  logic                strt_glitch,
  input  logic                par_err,
  input  logic                stp_err,
  output logic [PS_WIDTH-1:0] edge_cnt,
  output logic                dat_samp_en,
  output logic                deser_en,
  output logic                strt_chk_en,
  output logic                par_chk_en,
  output logic                stp_chk_en,
  output logic                data_valid,
  output logic                frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [BC_WIDTH-1:0] c_last_data_bit = BC_WIDTH'(DATA_WIDTH);

  state_t              r_state;
  state_t              w_next;
  logic [PS_WIDTH-1:0] r_edge_cnt;
  logic [BC_WIDTH-1:0] r_bit_cnt;
  logic [PS_WIDTH-1:0] r_prescale;   // frame-local copy, immune to mid-frame changes
  logic                r_par_en;
  logic                r_par_err_q;
  logic [PS_WIDTH-1:0] w_last_edge;
  logic [PS_WIDTH-1:0] w_chk_edge;
  logic                w_bit_end;
  logic                w_frame_done;
  logic                w_err;

  // Checkers register their flag one cycle before the FSM consumes it,
  // so their enables fire on the second-to-last edge of the bit.
  assign w_last_edge  = r_prescale - PS_WIDTH'(1);
  assign w_chk_edge   = r_prescale - PS_WIDTH'(2);
  assign w_bit_end    = (r_state != IDLE) && (r_edge_cnt == w_last_edge);
  assign w_frame_done = (r_state == STOP) && w_bit_end;
  assign w_err        = stp_err | r_par_err_q;
  assign edge_cnt     = r_edge_cnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state enables
  always_comb begin
    w_next      = r_state;
    dat_samp_en = (r_state != IDLE);
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!RX_IN) w_next = START;
      end
      START: begin
        strt_chk_en = (r_edge_cnt == w_chk_edge);
        if (w_bit_end) w_next = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser_en = (r_edge_cnt == w_last_edge);
        if (w_bit_end && (r_bit_cnt == c_last_data_bit)) begin
          w_next = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk_en = (r_edge_cnt == w_chk_edge);
        if (w_bit_end) w_next = STOP;
      end
      STOP: begin
        stp_chk_en = (r_edge_cnt == w_chk_edge);
        if (w_bit_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Edge/bit counters, frame configuration latch and parity-error capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_prescale  <= '0;
      r_par_en    <= 1'b0;
      r_par_err_q <= 1'b0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
      if (!RX_IN) begin
        // Detect cycle counts as edge 0 of the start bit.
        r_edge_cnt  <= PS_WIDTH'(1);
        r_prescale  <= Prescale;
        r_par_en    <= PAR_EN;
        r_par_err_q <= 1'b0;
      end else begin
        r_edge_cnt <= '0;
      end
    end else if (w_bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= (w_next == IDLE) ? '0 : r_bit_cnt + BC_WIDTH'(1);
      if (r_state == PARITY) r_par_err_q <= par_err;
    end else begin
      r_edge_cnt <= r_edge_cnt + PS_WIDTH'(1);
    end
  end

  // Per-frame result pulses, one cycle after the stop bit ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= w_frame_done & ~w_err;
      frame_err  <= w_frame_done &  w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Directed bench for uart_rx_ctrl. A frame-offset model predicts
//            every output each cycle; literal checks pin pulse timing/counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DW  = 8;
  localparam int PSW = 6;
  localparam int BCW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           RX_IN = 1'b1;
  logic           PAR_EN = 1'b0;
  logic [PSW-1:0] Prescale = 6'd8;
  logic           strt_glitch = 1'b0;
  logic           par_err = 1'b0;
  logic           stp_err = 1'b0;
  logic [PSW-1:0] edge_cnt;
  logic           dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic           data_valid, frame_err;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PS_WIDTH(PSW), .BC_WIDTH(BCW)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: a frame is just an offset t from its detect cycle.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_P = 0;
  bit m_par = 1'b0;
  bit m_perr = 1'b0;
  bit m_dv = 1'b0;
  bit m_fe = 1'b0;

  // Advance the model on each clock, abort on reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_t <= 0; m_P <= 0; m_par <= 1'b0;
      m_perr <= 1'b0; m_dv <= 1'b0; m_fe <= 1'b0;
    end else begin
      m_dv <= 1'b0;
      m_fe <= 1'b0;
      if (!m_active) begin
        if (!RX_IN) begin
          m_active <= 1'b1; m_t <= 1; m_P <= int'(Prescale);
          m_par <= PAR_EN; m_perr <= 1'b0;
        end
      end else if (m_t == m_P - 1 && strt_glitch) begin
        m_active <= 1'b0; m_t <= 0;
      end else if (m_t == m_P * (DW + 2 + int'(m_par)) - 1) begin
        m_active <= 1'b0; m_t <= 0;
        m_dv <= !(stp_err | m_perr);
        m_fe <= stp_err | m_perr;
      end else begin
        if (m_par && m_t == (DW + 2) * m_P - 1) m_perr <= par_err;
        m_t <= m_t + 1;
      end
    end
  end

  int n_deser = 0, n_parchk = 0, n_dv = 0, n_fe = 0;
  int last_dv = -1, prev_dv = -1, last_fe = -1;

  // Per-cycle comparison against the model, plus event tallies
  always @(negedge clk) begin : cmp
    int e;
    int b;
    if (m_active) begin
      e = m_t % m_P;
      b = m_t / m_P;
    end else begin
      e = 0;
      b = 0;
    end
    check("edge_cnt", 32'(edge_cnt), e);
    check("dat_samp_en", 32'(dat_samp_en), 32'(m_active));
    check("deser_en", 32'(deser_en), 32'(m_active && b >= 1 && b <= DW && e == m_P - 1));
    check("strt_chk_en", 32'(strt_chk_en), 32'(m_active && b == 0 && e == m_P - 2));
    check("par_chk_en", 32'(par_chk_en), 32'(m_active && m_par && b == DW + 1 && e == m_P - 2));
    check("stp_chk_en", 32'(stp_chk_en), 32'(m_active && b == DW + 1 + int'(m_par) && e == m_P - 2));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    if (deser_en === 1'b1) n_deser++;
    if (par_chk_en === 1'b1) n_parchk++;
    if (data_valid === 1'b1) begin n_dv++; prev_dv = last_dv; last_dv = cyc; end
    if (frame_err === 1'b1) begin n_fe++; last_fe = cyc; end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    end
  endtask

  // Drive one full frame; config inputs are scrambled after the start bit.
  task automatic run_frame(input int P, input bit par, input logic [7:0] data,
                           input bit perr, input bit serr, output int d);
    int n;
    int b;
    n = DW + 2 + int'(par);
    d = 0;
    for (int t = 0; t < n * P; t++) begin
      step();
      if (t == 0) begin d = cyc; Prescale = PSW'(P); PAR_EN = par; end
      if (t == P) begin Prescale = (P == 8) ? 6'd16 : 6'd8; PAR_EN = !par; end
      b = t / P;
      if (b == 0)                    RX_IN = 1'b0;
      else if (b <= DW)              RX_IN = data[b-1];
      else if (par && b == DW + 1)   RX_IN = ^data;
      else                           RX_IN = 1'b1;
      strt_glitch = 1'b0;
      par_err = perr && (t == (DW + 2) * P - 1);
      stp_err = serr && (t == n * P - 1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int d, d2, s_deser, s_par, s_dv, s_fe;
    #1 rst = 1'b0;
    idle(3);
    check("reset_edge_cnt", 32'(edge_cnt), 0);
    check("reset_samp_en", 32'(dat_samp_en), 0);
    check("reset_pulses", 32'({data_valid, frame_err}), 0);
    rst = 1'b1;
    idle(3);

    // T1: clean frame with parity
    s_deser = n_deser; s_dv = n_dv; s_fe = n_fe;
    run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, d);
    idle(3);
    check("t1_deser_count", 32'(n_deser - s_deser), 8);
    check("t1_dv_count", 32'(n_dv - s_dv), 1);
    check("t1_dv_time", 32'(last_dv - d), 88);
    check("t1_fe_count", 32'(n_fe - s_fe), 0);

    // T2: parity error
    s_dv = n_dv; s_fe = n_fe;
    run_frame(8, 1'b1, 8'hA5, 1'b1, 1'b0, d);
    idle(3);
    check("t2_fe_time", 32'(last_fe - d), 88);
    check("t2_fe_count", 32'(n_fe - s_fe), 1);
    check("t2_dv_count", 32'(n_dv - s_dv), 0);

    // T3: start glitch aborts silently
    s_deser = n_deser; s_dv = n_dv; s_fe = n_fe;
    for (int t = 0; t < 8; t++) begin
      step();
      if (t == 0) begin d = cyc; Prescale = 6'd8; PAR_EN = 1'b1; end
      RX_IN = (t < 2) ? 1'b0 : 1'b1;
      strt_glitch = (t == 7);
    end
    step();
    RX_IN = 1'b1; strt_glitch = 1'b0;
    check("t3_idle_at_8", 32'(cyc - d), 8);
    check("t3_samp_en", 32'(dat_samp_en), 0);
    idle(3);
    check("t3_no_deser", 32'(n_deser - s_deser), 0);
    check("t3_no_pulse", 32'((n_dv - s_dv) + (n_fe - s_fe)), 0);

    // T4: no parity, stop error (stray par_err must be ignored)
    s_par = n_parchk; s_dv = n_dv; s_fe = n_fe;
    run_frame(16, 1'b0, 8'h3C, 1'b1, 1'b1, d);
    idle(3);
    check("t4_no_par_chk", 32'(n_parchk - s_par), 0);
    check("t4_fe_time", 32'(last_fe - d), 160);
    check("t4_dv_count", 32'(n_dv - s_dv), 0);

    // T5: back-to-back frames at P=16 with parity
    s_dv = n_dv;
    run_frame(16, 1'b1, 8'h5A, 1'b0, 1'b0, d);
    run_frame(16, 1'b1, 8'hC3, 1'b0, 1'b0, d2);
    idle(3);
    check("t5_dv_count", 32'(n_dv - s_dv), 2);
    check("t5_dv_spacing", 32'(last_dv - prev_dv), 176);
    check("t5_second_detect", 32'(d2 - d), 176);

    // T6: reset in the middle of data bit 4
    s_dv = n_dv; s_fe = n_fe;
    for (int t = 0; t <= 4 * 8 + 3; t++) begin
      step();
      if (t == 0) begin Prescale = 6'd8; PAR_EN = 1'b1; end
      RX_IN = (t < 8) ? 1'b0 : 1'b1;
    end
    rst = 1'b0;
    step();
    check("t6_samp_en", 32'(dat_samp_en), 0);
    check("t6_edge_cnt", 32'(edge_cnt), 0);
    check("t6_enables", 32'({deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    rst = 1'b1;
    idle(3);
    check("t6_no_pulse", 32'((n_dv - s_dv) + (n_fe - s_fe)), 0);
    run_frame(8, 1'b1, 8'h81, 1'b0, 1'b0, d);
    idle(3);
    check("t6_recover_dv", 32'(last_dv - d), 88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
